mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single external memory port (mem_addr/mem_in/mem_out/mem_out_valid/mem_rdreq/mem_wrreq/mem_burstlen) between icache (read-only, port 0) and dcache (read/write, port 1).
- Arbitrates whole bursts, forwards one command, then routes read beats back to the owner or sequences write beats with incrementing addresses.
- Sits between the cache layer and the memory controller/spram model.

Parameters:
- DATABITS, 32, data word width.
- ADDRBITS, 32, byte address width.
- BURSTBITS, 16, width of burst length fields.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ic_addr  in  ADDRBITS  icache burst start byte address.
- ic_rdreq  in  1  icache read request; held high until ic_gnt.
- ic_burstlen  in  BURSTBITS  icache words per burst.
- ic_gnt  out  1  one-cycle grant pulse (command accepted).
- ic_out  out  DATABITS  read data (= mem_out).
- ic_out_valid  out  1  read beat valid for icache.
- dc_addr  in  ADDRBITS  dcache burst start byte address.
- dc_in  in  DATABITS  dcache write data, current beat.
- dc_rdreq  in  1  dcache read request; held until dc_gnt.
- dc_wrreq  in  1  dcache write request / write beat strobe.
- dc_burstlen  in  BURSTBITS  dcache words per burst.
- dc_gnt  out  1  one-cycle grant pulse.
- dc_out  out  DATABITS  read data (= mem_out).
- dc_out_valid  out  1  read beat valid for dcache.
- mem_addr  out  ADDRBITS  memory byte address.
- mem_in  out  DATABITS  write data to memory.
- mem_out  in  DATABITS  read data from memory.
- mem_out_valid  in  1  read beat valid from memory.
- mem_rdreq  out  1  one-cycle read command.
- mem_wrreq  out  1  write beat strobe; memory accepts one word per cycle.
- mem_burstlen  out  BURSTBITS  burst length of the current command.

Behaviour:
- States: IDLE, READ, WRITE.
- Reset (async): state IDLE, beat counter 0, rr pointer selects dcache first; all gnt, valid, mem_rdreq and mem_wrreq outputs 0; mem_addr, mem_in and mem_burstlen 0.
- A dcache request is dc_wrreq|dc_rdreq. If both are high, the write wins.
- IDLE: pick a winner from the pending requests, combinationally, in the same cycle.
  - Drive the winner's gnt=1.
  - Drive mem_addr=addr and mem_burstlen=burstlen (burstlen 0 is treated as 1).
  - For a read, pulse mem_rdreq=1 and go to READ.
  - For a write, assert mem_wrreq=1 with mem_in=dc_in. This is beat 0. If burstlen≤1, stay IDLE; otherwise go to WRITE.
  - After any grant, the rr pointer flips to favour the other port.
- READ:
  - mem_addr and mem_burstlen are held at their registered values.
  - Each mem_out_valid is routed combinationally (zero latency) to the owner's out_valid and increments the beat count.
  - On the beat count reaching burstlen, return to IDLE. The next grant is possible in the cycle after the last beat.
  - gnt stays 0 for both ports.
- WRITE:
  - A beat occurs each cycle dc_wrreq=1: mem_wrreq=1, mem_in=dc_in, mem_addr=base+4*beat.
  - A cycle with dc_wrreq=0 is a stall: mem_wrreq=0 and the count is held.
  - After the last beat, return to IDLE.
- Outside READ, mem_out_valid is ignored; stray beats are dropped and both out_valid outputs stay 0.
- Beat counter width is BURSTBITS. Address arithmetic wraps modulo 2^ADDRBITS.
- Requests that arrive during a burst wait; requesters keep them asserted.
- A reset mid-burst aborts the burst immediately. Memory beats still in flight are discarded.

Optional Feature:
- Macro MEM_ARBITER_DCACHE_PRIO_EN.
- Defined: fixed priority. dcache always wins a simultaneous request; the rr pointer is removed. icache can starve while dcache keeps requesting.
- Undefined (default): 2-way round-robin as described above.

Decomposition:
- Shared include header (mem_arbiter_defs.vh) holds:
  - state encodings (IDLE/READ/WRITE, 2 bits);
  - port index constants (PORT_IC=0, PORT_DC=1);
  - the word byte-stride constant 4.
- Sub-module mem_arbiter_rr: 2-input round-robin picker with registered pointer. Inputs req[1:0] and advance; output one-hot gnt[1:0]. Compiled to fixed priority under the macro.

Test Plan:
- Single icache read, burstlen 4, ic_addr=0x100:
  - ic_gnt, mem_rdreq and mem_addr=0x100 appear in the same cycle.
  - Four mem_out_valid beats yield four ic_out_valid beats; dc_out_valid stays 0; state returns to IDLE.
- dcache write, burstlen 4, dc_addr=0x80, data 0x0fff0001..4, dc_wrreq low for 2 cycles after beat 1:
  - mem_addr sequence 0x80, 0x84, 0x88, 0x8c.
  - mem_wrreq low during the stall; memory contents are correct.
  - Read-back through dcache returns the same data.
- Simultaneous ic_rdreq and dc_rdreq held for 3 bursts each:
  - Grants alternate dcache, icache, dcache, … (default build).
  - With MEM_ARBITER_DCACHE_PRIO_EN, all dcache grants come first.
- dc_rdreq and dc_wrreq both high, burstlen 1: write is performed, mem_rdreq stays 0.
- burstlen=0 read: treated as 1 beat; returns to IDLE after a single mem_out_valid.
- reset_n pulsed low during beat 2 of a 4-beat read:
  - All outputs go 0 asynchronously; state is IDLE.
  - Later mem_out_valid beats produce no out_valid.
  - A new icache request is granted normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the memory-port arbiter:
//   state_e      - arbiter FSM states (IDLE/READ/WRITE, 2-bit encoding)
//   PORT_IC/DC   - requester indices into the 2-bit request/grant vectors
//   WORD_STRIDE  - byte distance between consecutive burst words
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  localparam bit PORT_IC = 1'b0;
  localparam bit PORT_DC = 1'b1;

  localparam int unsigned WORD_STRIDE = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the icache, dcache and external memory signals around the arbiter.
//   slave  : arbiter view (cache requests and memory read data in; grants,
//            cache read data and memory commands out)
//   master : environment view (caches + memory controller), the reverse
// Parameters: DATABITS (data word), ADDRBITS (byte address), BURSTBITS (burst
// length fields).
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int DATABITS  = 32,
  parameter int ADDRBITS  = 32,
  parameter int BURSTBITS = 16
);

  // icache (read-only)
  logic [ADDRBITS-1:0]  ic_addr;
  logic                 ic_rdreq;
  logic [BURSTBITS-1:0] ic_burstlen;
  logic                 ic_gnt;
  logic [DATABITS-1:0]  ic_out;
  logic                 ic_out_valid;

  // dcache (read/write)
  logic [ADDRBITS-1:0]  dc_addr;
  logic [DATABITS-1:0]  dc_in;
  logic                 dc_rdreq;
  logic                 dc_wrreq;
  logic [BURSTBITS-1:0] dc_burstlen;
  logic                 dc_gnt;
  logic [DATABITS-1:0]  dc_out;
  logic                 dc_out_valid;

  // external memory port
  logic [ADDRBITS-1:0]  mem_addr;
  logic [DATABITS-1:0]  mem_in;
  logic [DATABITS-1:0]  mem_out;
  logic                 mem_out_valid;
  logic                 mem_rdreq;
  logic                 mem_wrreq;
  logic [BURSTBITS-1:0] mem_burstlen;

  modport slave (
    input  ic_addr, ic_rdreq, ic_burstlen,
    output ic_gnt, ic_out, ic_out_valid,
    input  dc_addr, dc_in, dc_rdreq, dc_wrreq, dc_burstlen,
    output dc_gnt, dc_out, dc_out_valid,
    output mem_addr, mem_in, mem_rdreq, mem_wrreq, mem_burstlen,
    input  mem_out, mem_out_valid
  );

  modport master (
    output ic_addr, ic_rdreq, ic_burstlen,
    input  ic_gnt, ic_out, ic_out_valid,
    output dc_addr, dc_in, dc_rdreq, dc_wrreq, dc_burstlen,
    input  dc_gnt, dc_out, dc_out_valid,
    input  mem_addr, mem_in, mem_rdreq, mem_wrreq, mem_burstlen,
    output mem_out, mem_out_valid
  );

endinterface

// File: rtl/mem_arbiter_rr.sv
// -----------------------------------------------------------------------------
// mem_arbiter_rr
// Two-input picker for the memory arbiter.
//   clk, reset_n : clock, asynchronous active-low reset
//   req[1:0]     : pending requests (index PORT_IC / PORT_DC)
//   advance      : a grant was taken this cycle, move the pointer
//   gnt[1:0]     : one-hot winner (combinational)
// Default build: round-robin, pointer favours dcache after reset and then the
// port that did not win last. With MEM_ARBITER_DCACHE_PRIO_EN defined the
// pointer is removed and dcache always wins.
// -----------------------------------------------------------------------------
module mem_arbiter_rr
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

`ifdef MEM_ARBITER_DCACHE_PRIO_EN

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt = 2'b00;
    if (req[PORT_DC]) begin
      gnt[PORT_DC] = 1'b1;
    end else if (req[PORT_IC]) begin
      gnt[PORT_IC] = 1'b1;
    end
  end

  // Fixed priority needs no state; these inputs are intentionally unused.
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, reset_n, advance};

`else

  logic prio_dc_q, prio_dc_d;

  always_comb begin
    gnt = 2'b00;
    if (req[PORT_DC] && (prio_dc_q || !req[PORT_IC])) begin
      gnt[PORT_DC] = 1'b1;
    end else if (req[PORT_IC]) begin
      gnt[PORT_IC] = 1'b1;
    end
  end

  // After a grant, favour whichever port did not win.
  always_comb begin
    prio_dc_d = prio_dc_q;
    if (advance) begin
      prio_dc_d = gnt[PORT_IC];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_dc_q <= 1'b1;
    end else begin
      prio_dc_q <= prio_dc_d;
    end
  end

`endif

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one external memory port between icache (read-only, port 0) and
// dcache (read/write, port 1). Whole bursts are arbitrated: in IDLE the winner
// is granted and its command forwarded in the same cycle; READ routes memory
// beats to the owner with zero latency; WRITE sequences dcache beats at
// base + 4*beat, stalling while dc_wrreq is low.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : mem_arbiter_if.slave (icache, dcache and memory signals)
// Configuration macro: MEM_ARBITER_DCACHE_PRIO_EN selects fixed dcache
// priority instead of round-robin.
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATABITS  = 32,
  parameter int ADDRBITS  = 32,
  parameter int BURSTBITS = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  mem_arbiter_if.slave   bus
);

  state_e               state_q, state_d;
  logic [BURSTBITS-1:0] beat_q, beat_d;
  logic [BURSTBITS-1:0] burstlen_q, burstlen_d;
  logic [ADDRBITS-1:0]  base_q, base_d;
  logic                 owner_q, owner_d;

  logic [1:0]           req, gnt;
  logic                 advance;
  logic [BURSTBITS-1:0] beat_inc;
  logic [BURSTBITS-1:0] ic_len_eff, dc_len_eff;
  logic [ADDRBITS-1:0]  wr_addr;

  logic                 ic_gnt_c, dc_gnt_c, ic_valid_c, dc_valid_c;
  logic                 mem_rdreq_c, mem_wrreq_c;
  logic [ADDRBITS-1:0]  mem_addr_c;
  logic [DATABITS-1:0]  mem_in_c;
  logic [BURSTBITS-1:0] mem_burstlen_c;

  assign req        = {bus.dc_wrreq | bus.dc_rdreq, bus.ic_rdreq};
  assign beat_inc   = beat_q + BURSTBITS'(1);
  assign ic_len_eff = (bus.ic_burstlen == '0) ? BURSTBITS'(1) : bus.ic_burstlen;
  assign dc_len_eff = (bus.dc_burstlen == '0) ? BURSTBITS'(1) : bus.dc_burstlen;
  assign wr_addr    = base_q + ADDRBITS'(beat_q) * ADDRBITS'(WORD_STRIDE);

  mem_arbiter_rr u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .advance (advance),
    .gnt     (gnt)
  );

  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    burstlen_d     = burstlen_q;
    base_d         = base_q;
    owner_d        = owner_q;
    advance        = 1'b0;
    ic_gnt_c       = 1'b0;
    dc_gnt_c       = 1'b0;
    ic_valid_c     = 1'b0;
    dc_valid_c     = 1'b0;
    mem_rdreq_c    = 1'b0;
    mem_wrreq_c    = 1'b0;
    mem_addr_c     = base_q;
    mem_in_c       = '0;
    mem_burstlen_c = burstlen_q;

    // Outputs are partly combinational from requests; gating them with
    // reset_n keeps every command and grant quiet while reset is asserted.
    if (reset_n) begin
      case (state_q)
        ST_IDLE: begin
          if (gnt[PORT_DC]) begin
            advance        = 1'b1;
            dc_gnt_c       = 1'b1;
            mem_addr_c     = bus.dc_addr;
            mem_burstlen_c = dc_len_eff;
            base_d         = bus.dc_addr;
            burstlen_d     = dc_len_eff;
            owner_d        = PORT_DC;
            beat_d         = '0;
            if (bus.dc_wrreq) begin
              // Write wins over a simultaneous dcache read; this is beat 0.
              mem_wrreq_c = 1'b1;
              mem_in_c    = bus.dc_in;
              if (dc_len_eff > BURSTBITS'(1)) begin
                state_d = ST_WRITE;
                beat_d  = BURSTBITS'(1);
              end
            end else begin
              mem_rdreq_c = 1'b1;
              state_d     = ST_READ;
            end
          end else if (gnt[PORT_IC]) begin
            advance        = 1'b1;
            ic_gnt_c       = 1'b1;
            mem_addr_c     = bus.ic_addr;
            mem_burstlen_c = ic_len_eff;
            base_d         = bus.ic_addr;
            burstlen_d     = ic_len_eff;
            owner_d        = PORT_IC;
            beat_d         = '0;
            mem_rdreq_c    = 1'b1;
            state_d        = ST_READ;
          end
        end

        ST_READ: begin
          if (bus.mem_out_valid) begin
            if (owner_q == PORT_DC) begin
              dc_valid_c = 1'b1;
            end else begin
              ic_valid_c = 1'b1;
            end
            if (beat_inc == burstlen_q) begin
              state_d = ST_IDLE;
              beat_d  = '0;
            end else begin
              beat_d = beat_inc;
            end
          end
        end

        ST_WRITE: begin
          mem_addr_c = wr_addr;
          if (bus.dc_wrreq) begin
            mem_wrreq_c = 1'b1;
            mem_in_c    = bus.dc_in;
            if (beat_inc == burstlen_q) begin
              state_d = ST_IDLE;
              beat_d  = '0;
            end else begin
              beat_d = beat_inc;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
          beat_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      burstlen_q <= '0;
      base_q     <= '0;
      owner_q    <= PORT_IC;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      burstlen_q <= burstlen_d;
      base_q     <= base_d;
      owner_q    <= owner_d;
    end
  end

  assign bus.ic_gnt       = ic_gnt_c;
  assign bus.dc_gnt       = dc_gnt_c;
  assign bus.ic_out       = bus.mem_out;
  assign bus.dc_out       = bus.mem_out;
  assign bus.ic_out_valid = ic_valid_c;
  assign bus.dc_out_valid = dc_valid_c;
  assign bus.mem_addr     = mem_addr_c;
  assign bus.mem_in       = mem_in_c;
  assign bus.mem_rdreq    = mem_rdreq_c;
  assign bus.mem_wrreq    = mem_wrreq_c;
  assign bus.mem_burstlen = mem_burstlen_c;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed self-checking bench for mem_arbiter. Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge (or mid-cycle
// around the asynchronous reset pulse). A small word memory records what the
// arbiter writes so the dcache read-back can be served from it.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [31:0] tb_mem [256];

  mem_arbiter_if #(.DATABITS(32), .ADDRBITS(32), .BURSTBITS(16)) bus ();

  mem_arbiter #(.DATABITS(32), .ADDRBITS(32), .BURSTBITS(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Memory model: accepts one write word per cycle.
  always @(posedge clk) begin
    if (bus.mem_wrreq) tb_mem[bus.mem_addr[9:2]] <= bus.mem_in;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_edge();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  // Expected grant order {dc_gnt, ic_gnt} for six contending bursts.
  logic [1:0] rr_exp [6];
  logic [1:0] g;

  initial begin
`ifdef MEM_ARBITER_DCACHE_PRIO_EN
    rr_exp = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01};
`else
    rr_exp = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
`endif
    for (int i = 0; i < 256; i++) tb_mem[i] = '0;
    bus.ic_addr = '0; bus.ic_rdreq = 1'b0; bus.ic_burstlen = '0;
    bus.dc_addr = '0; bus.dc_in = '0; bus.dc_rdreq = 1'b0; bus.dc_wrreq = 1'b0;
    bus.dc_burstlen = '0; bus.mem_out = '0; bus.mem_out_valid = 1'b0;

    // ---------------- reset state ----------------
    #2 reset_n = 1'b0;
    sample_edge();
    check("rst_state", dut.state_q, ST_IDLE);
    check("rst_gnt_valid", {bus.ic_gnt, bus.dc_gnt, bus.ic_out_valid, bus.dc_out_valid}, 4'b0);
    check("rst_mem_cmd", {bus.mem_rdreq, bus.mem_wrreq}, 2'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_in", bus.mem_in, 32'h0);
    check("rst_mem_burstlen", bus.mem_burstlen, 16'h0);
    reset_n = 1'b1;

    // ---------------- icache read, 4 beats at 0x100 ----------------
    drive_edge();
    bus.ic_rdreq = 1'b1; bus.ic_addr = 32'h100; bus.ic_burstlen = 16'd4;
    sample_edge();
    check("ic_rd_gnt", {bus.dc_gnt, bus.ic_gnt}, 2'b01);
    check("ic_rd_mem_rdreq", bus.mem_rdreq, 1'b1);
    check("ic_rd_mem_addr", bus.mem_addr, 32'h100);
    check("ic_rd_mem_burstlen", bus.mem_burstlen, 16'd4);
    for (int i = 0; i < 4; i++) begin
      drive_edge();
      bus.ic_rdreq = 1'b0;
      if (i == 2) begin
        bus.mem_out_valid = 1'b0;
        sample_edge();
        check("ic_rd_gap_valid", bus.ic_out_valid, 1'b0);
        drive_edge();
      end
      bus.mem_out_valid = 1'b1; bus.mem_out = 32'hA000_0000 + i;
      sample_edge();
      check("ic_rd_valid", {bus.dc_out_valid, bus.ic_out_valid}, 2'b01);
      check("ic_rd_data", bus.ic_out, 32'hA000_0000 + i);
      check("ic_rd_addr_held", bus.mem_addr, 32'h100);
      check("ic_rd_no_cmd", {bus.mem_rdreq, bus.ic_gnt}, 2'b00);
    end
    drive_edge();
    bus.mem_out = 32'h5555_5555;              // stray beat after the burst
    sample_edge();
    check("ic_rd_idle", dut.state_q, ST_IDLE);
    check("ic_rd_stray_dropped", {bus.dc_out_valid, bus.ic_out_valid}, 2'b00);
    drive_edge();
    bus.mem_out_valid = 1'b0;

    // ---------------- dcache write, 4 beats at 0x80, 2-cycle stall ----------------
    begin
      int b;
      b = 0;
      for (int c = 0; c < 6; c++) begin
        drive_edge();
        if (c == 0) begin
          bus.dc_addr = 32'h80; bus.dc_burstlen = 16'd4;
        end
        if (c == 2 || c == 3) begin
          bus.dc_wrreq = 1'b0;
          sample_edge();
          check("wr_stall_wrreq", bus.mem_wrreq, 1'b0);
        end else begin
          bus.dc_wrreq = 1'b1; bus.dc_in = 32'h0fff_0001 + b;
          sample_edge();
          check("wr_beat_gnt", bus.dc_gnt, (c == 0));
          check("wr_beat_wrreq", {bus.mem_wrreq, bus.mem_rdreq}, 2'b10);
          check("wr_beat_addr", bus.mem_addr, 32'h80 + 4 * b);
          check("wr_beat_data", bus.mem_in, 32'h0fff_0001 + b);
          b++;
        end
      end
    end
    drive_edge();
    bus.dc_wrreq = 1'b0;
    sample_edge();
    check("wr_done_idle", dut.state_q, ST_IDLE);
    check("wr_done_quiet", {bus.mem_wrreq, bus.dc_gnt}, 2'b00);
    for (int i = 0; i < 4; i++) check("wr_mem_contents", tb_mem[32 + i], 32'h0fff_0001 + i);

    // dcache read-back of the same burst, data served from the memory model
    drive_edge();
    bus.dc_rdreq = 1'b1; bus.dc_addr = 32'h80; bus.dc_burstlen = 16'd4;
    sample_edge();
    check("rb_gnt", {bus.dc_gnt, bus.ic_gnt}, 2'b10);
    check("rb_cmd", {bus.mem_rdreq, bus.mem_wrreq}, 2'b10);
    check("rb_addr", bus.mem_addr, 32'h80);
    for (int i = 0; i < 4; i++) begin
      drive_edge();
      bus.dc_rdreq = 1'b0; bus.mem_out_valid = 1'b1; bus.mem_out = tb_mem[32 + i];
      sample_edge();
      check("rb_valid", {bus.dc_out_valid, bus.ic_out_valid}, 2'b10);
      check("rb_data", bus.dc_out, 32'h0fff_0001 + i);
    end
    drive_edge();
    bus.mem_out_valid = 1'b0;
    sample_edge();
    check("rb_idle", dut.state_q, ST_IDLE);

    // ---------------- dc_rdreq and dc_wrreq together, burstlen 1 ----------------
    drive_edge();
    bus.dc_rdreq = 1'b1; bus.dc_wrreq = 1'b1; bus.dc_addr = 32'h40;
    bus.dc_burstlen = 16'd1; bus.dc_in = 32'hDEAD_BEEF;
    sample_edge();
    check("rw_gnt", bus.dc_gnt, 1'b1);
    check("rw_cmd", {bus.mem_wrreq, bus.mem_rdreq}, 2'b10);
    check("rw_addr", bus.mem_addr, 32'h40);
    check("rw_data", bus.mem_in, 32'hDEAD_BEEF);
    drive_edge();
    bus.dc_rdreq = 1'b0; bus.dc_wrreq = 1'b0;
    sample_edge();
    check("rw_stays_idle", dut.state_q, ST_IDLE);
    check("rw_quiet", {bus.mem_wrreq, bus.mem_rdreq}, 2'b00);
    check("rw_mem_contents", tb_mem[16], 32'hDEAD_BEEF);

    // ---------------- burstlen 0 read is one beat ----------------
    drive_edge();
    bus.ic_rdreq = 1'b1; bus.ic_addr = 32'h200; bus.ic_burstlen = 16'd0;
    sample_edge();
    check("bl0_gnt", bus.ic_gnt, 1'b1);
    check("bl0_burstlen", bus.mem_burstlen, 16'd1);
    drive_edge();
    bus.ic_rdreq = 1'b0; bus.mem_out_valid = 1'b1; bus.mem_out = 32'h0000_0B10;
    sample_edge();
    check("bl0_valid", bus.ic_out_valid, 1'b1);
    drive_edge();
    bus.mem_out_valid = 1'b0;
    sample_edge();
    check("bl0_idle", dut.state_q, ST_IDLE);

    // ---------------- reset during beat 2 of a 4-beat read ----------------
    drive_edge();
    bus.ic_rdreq = 1'b1; bus.ic_addr = 32'h300; bus.ic_burstlen = 16'd4;
    sample_edge();
    check("rstmid_gnt", bus.ic_gnt, 1'b1);
    for (int i = 0; i < 2; i++) begin
      drive_edge();
      bus.ic_rdreq = 1'b0; bus.mem_out_valid = 1'b1; bus.mem_out = 32'hC000_0000 + i;
      sample_edge();
      check("rstmid_pre_valid", bus.ic_out_valid, 1'b1);
    end
    drive_edge();
    bus.mem_out = 32'hC000_0002;
    #1 reset_n = 1'b0;
    #1;
    check("rstmid_state", dut.state_q, ST_IDLE);
    check("rstmid_gnt_valid", {bus.ic_gnt, bus.dc_gnt, bus.ic_out_valid, bus.dc_out_valid}, 4'b0);
    check("rstmid_cmd", {bus.mem_rdreq, bus.mem_wrreq}, 2'b0);
    check("rstmid_addr_len", {bus.mem_addr, bus.mem_burstlen}, 48'h0);
    sample_edge();
    reset_n = 1'b1;
    drive_edge();
    bus.mem_out = 32'hC000_0003;              // in-flight beat after reset
    sample_edge();
    check("rstmid_stray_dropped", {bus.dc_out_valid, bus.ic_out_valid}, 2'b00);
    drive_edge();
    bus.mem_out_valid = 1'b0;
    bus.ic_rdreq = 1'b1; bus.ic_addr = 32'h104; bus.ic_burstlen = 16'd1;
    sample_edge();
    check("rstmid_new_gnt", {bus.dc_gnt, bus.ic_gnt}, 2'b01);
    check("rstmid_new_addr", bus.mem_addr, 32'h104);
    check("rstmid_new_rdreq", bus.mem_rdreq, 1'b1);
    drive_edge();
    bus.ic_rdreq = 1'b0; bus.mem_out_valid = 1'b1; bus.mem_out = 32'hD000_0001;
    sample_edge();
    check("rstmid_new_valid", bus.ic_out_valid, 1'b1);
    drive_edge();
    bus.mem_out_valid = 1'b0;

    // ---------------- contention: both caches request 3 bursts each ----------------
    begin
      int ic_cnt, dc_cnt;
      ic_cnt = 0; dc_cnt = 0;
      bus.ic_rdreq = 1'b1; bus.ic_addr = 32'h400; bus.ic_burstlen = 16'd1;
      bus.dc_rdreq = 1'b1; bus.dc_addr = 32'h500; bus.dc_burstlen = 16'd1;
      for (int k = 0; k < 6; k++) begin
        sample_edge();
        g = {bus.dc_gnt, bus.ic_gnt};
        check($sformatf("rr_gnt_%0d", k), g, rr_exp[k]);
        drive_edge();
        if (g[1]) begin
          dc_cnt++;
          if (dc_cnt == 3) bus.dc_rdreq = 1'b0;
        end
        if (g[0]) begin
          ic_cnt++;
          if (ic_cnt == 3) bus.ic_rdreq = 1'b0;
        end
        bus.mem_out_valid = 1'b1; bus.mem_out = 32'hE000_0000 + k;
        sample_edge();
        check($sformatf("rr_owner_%0d", k), {bus.dc_out_valid, bus.ic_out_valid}, rr_exp[k]);
        drive_edge();
        bus.mem_out_valid = 1'b0;
      end
      bus.ic_rdreq = 1'b0; bus.dc_rdreq = 1'b0;
      sample_edge();
      check("rr_final_idle", dut.state_q, ST_IDLE);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
